// File: rtl/uart_tx_word.sv
// Word-wide UART transmitter: sends a 32-bit word as four back-to-back 8N1 frames,
// least significant byte first, with per-byte and per-word completion pulses.
module uart_tx_word #(
    parameter int TAM_DATA = 32,
    parameter int TAM_BYTE = 8,
    parameter int BAUD_DIV = 2604
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [TAM_DATA-1:0] i_tx_data,
    input  logic                i_tx_start_32b,
    output logic                o_tx,
    output logic                o_busy,
    output logic                o_tx_done_8b_pulse,
    output logic                o_tx_done_32b_pulse
);

    localparam int NUM_BYTES = TAM_DATA / TAM_BYTE;
    localparam int CNT_W     = $clog2(BAUD_DIV);
    localparam int BIT_W     = $clog2(TAM_BYTE);
    localparam int BYTE_W    = $clog2(NUM_BYTES);

    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(TAM_BYTE - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t              state,     state_next;
    logic [CNT_W-1:0]    baud_cnt,  baud_cnt_next;
    logic [BIT_W-1:0]    bit_idx,   bit_idx_next;
    logic [BYTE_W-1:0]   byte_idx,  byte_idx_next;
    logic [TAM_DATA-1:0] shift_reg, shift_reg_next;

    logic tx_next;
    logic busy_next;
    logic done_8b_next;
    logic done_32b_next;
    logic baud_tick;

    assign baud_tick = (baud_cnt == BAUD_LAST);

    // Outputs are registered from the current state, so the line lags the FSM by
    // one cycle; the start bit therefore appears the cycle after acceptance.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case
        // leaves one unassigned, which would otherwise infer a latch.
        state_next     = state;
        baud_cnt_next  = baud_cnt + 1'b1;
        bit_idx_next   = bit_idx;
        byte_idx_next  = byte_idx;
        shift_reg_next = shift_reg;
        tx_next        = 1'b1;
        busy_next      = (state != IDLE);
        done_8b_next   = 1'b0;
        done_32b_next  = 1'b0;

        case (state)
            IDLE: begin
                baud_cnt_next = '0;
                if (i_tx_start_32b) begin
                    shift_reg_next = i_tx_data;
                    byte_idx_next  = '0;
                    bit_idx_next   = '0;
                    state_next     = START;
                end
            end

            START: begin
                tx_next = 1'b0;
                if (baud_tick) begin
                    baud_cnt_next = '0;
                    bit_idx_next  = '0;
                    state_next    = DATA;
                end
            end

            DATA: begin
                // Shifting right after each bit makes the next byte land in the
                // low bits once the current byte's 8 bits are out.
                tx_next = shift_reg[0];
                if (baud_tick) begin
                    baud_cnt_next  = '0;
                    shift_reg_next = shift_reg >> 1;
                    if (bit_idx == BIT_LAST) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end
            end

            STOP: begin
                tx_next = 1'b1;
                if (baud_tick) begin
                    baud_cnt_next = '0;
                    done_8b_next  = 1'b1;
                    if (byte_idx == BYTE_LAST) begin
                        done_32b_next = 1'b1;
                        state_next    = IDLE;
                    end else begin
                        byte_idx_next = byte_idx + 1'b1;
                        state_next    = START;
                    end
                end
            end

            default: begin
                state_next    = IDLE;
                baud_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (i_reset) begin
            state               <= IDLE;
            baud_cnt            <= '0;
            bit_idx             <= '0;
            byte_idx            <= '0;
            shift_reg           <= '0;
            o_tx                <= 1'b1;
            o_busy              <= 1'b0;
            o_tx_done_8b_pulse  <= 1'b0;
            o_tx_done_32b_pulse <= 1'b0;
        end else begin
            state               <= state_next;
            baud_cnt            <= baud_cnt_next;
            bit_idx             <= bit_idx_next;
            byte_idx            <= byte_idx_next;
            shift_reg           <= shift_reg_next;
            o_tx                <= tx_next;
            o_busy              <= busy_next;
            o_tx_done_8b_pulse  <= done_8b_next;
            o_tx_done_32b_pulse <= done_32b_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_word.sv
// Bench for uart_tx_word: two instances (BAUD_DIV 4 and 2) checked every cycle against
// a timing-formula model, plus line decoders and hand-computed literal expectations.
module tb_uart_tx_word;

    int bd [2] = '{4, 2};

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic [31:0] data  = '0;

    logic tx [2];
    logic busy [2];
    logic d8 [2];
    logic d32 [2];

    always #5 clk = ~clk;

    uart_tx_word #(.TAM_DATA(32), .TAM_BYTE(8), .BAUD_DIV(4)) dut4 (
        .i_clock(clk), .i_reset(rst), .i_tx_data(data), .i_tx_start_32b(start),
        .o_tx(tx[0]), .o_busy(busy[0]),
        .o_tx_done_8b_pulse(d8[0]), .o_tx_done_32b_pulse(d32[0])
    );

    uart_tx_word #(.TAM_DATA(32), .TAM_BYTE(8), .BAUD_DIV(2)) dut2 (
        .i_clock(clk), .i_reset(rst), .i_tx_data(data), .i_tx_start_32b(start),
        .o_tx(tx[1]), .o_busy(busy[1]),
        .o_tx_done_8b_pulse(d8[1]), .o_tx_done_32b_pulse(d32[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Model: a word accepted at edge t0 occupies cycles t0+1 .. t0+40*BD; each byte
    // is 10 bit slots of BD cycles (start, 8 data LSB first, stop).
    int          cyc   = 0;
    logic        valid = 1'b0;
    bit          act [2];
    int          t0m [2];
    logic [31:0] wd [2];
    logic        etx [2], ebusy [2], e8 [2], e32 [2];

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            int c;
            c = cyc - t0m[i];
            if (rst) begin
                act[i] = 1'b0;
            end else if (start && (!act[i] || c >= 40 * bd[i] + 1)) begin
                act[i] = 1'b1;
                t0m[i] = cyc;
                wd[i]  = data;
            end
            c = cyc - t0m[i];
            etx[i]   = 1'b1;
            ebusy[i] = 1'b0;
            e8[i]    = 1'b0;
            e32[i]   = 1'b0;
            if (act[i] && c >= 1 && c <= 40 * bd[i]) begin
                int k, r, slot;
                k    = (c - 1) / (10 * bd[i]);
                r    = (c - 1) % (10 * bd[i]);
                slot = r / bd[i];
                ebusy[i] = 1'b1;
                if (slot == 0)      etx[i] = 1'b0;
                else if (slot <= 8) etx[i] = wd[i][8 * k + slot - 1];
                else                etx[i] = 1'b1;
                e8[i]  = (r == 10 * bd[i] - 1);
                e32[i] = (c == 40 * bd[i]);
            end
        end
        if (rst) valid = 1'b1;
    end

    // Per-cycle compare plus event logs for the BAUD_DIV=4 instance.
    int   p8q [$];
    int   p32q [$];
    int   rise_q [$];
    int   fall_q [$];
    logic txhist [int];
    logic prev_busy0 = 1'b0;

    always @(negedge clk) begin
        if (valid) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("dut%0d tx/busy/d8/d32 @%0d", i, cyc),
                      {28'd0, tx[i], busy[i], d8[i], d32[i]},
                      {28'd0, etx[i], ebusy[i], e8[i], e32[i]});
            end
            txhist[cyc] = tx[0];
            if (d8[0] === 1'b1)  p8q.push_back(cyc);
            if (d32[0] === 1'b1) p32q.push_back(cyc);
            if (busy[0] === 1'b1 && !prev_busy0) rise_q.push_back(cyc);
            if (busy[0] === 1'b0 && prev_busy0)  fall_q.push_back(cyc);
            prev_busy0 = (busy[0] === 1'b1);
        end
    end

    // Independent line decoders: wait for a low, then sample mid-bit.
    logic [7:0] rxq [2][$];
    int         ferr [2] = '{0, 0};

    for (genvar g = 0; g < 2; g++) begin : rx
        initial begin
            logic [7:0] b;
            logic       fe;
            forever begin
                @(negedge clk);
                if (valid && tx[g] === 1'b0) begin
                    repeat (bd[g] / 2) @(negedge clk);
                    fe = (tx[g] !== 1'b0);
                    for (int n = 0; n < 8; n++) begin
                        repeat (bd[g]) @(negedge clk);
                        b[n] = tx[g];
                    end
                    repeat (bd[g]) @(negedge clk);
                    if (tx[g] !== 1'b1) fe = 1'b1;
                    rxq[g].push_back(b);
                    if (fe) ferr[g]++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic send(input logic [31:0] w, output int t);
        data  = w;
        start = 1'b1;
        tick();
        t     = cyc;
        start = 1'b0;
    endtask

    task automatic check_bytes(input int i, input string name, input logic [7:0] exp [$]);
        check($sformatf("%s byte count", name), rxq[i].size(), exp.size());
        if (rxq[i].size() == exp.size()) begin
            for (int j = 0; j < exp.size(); j++)
                check($sformatf("%s byte %0d", name, j), rxq[i][j], exp[j]);
        end
    endtask

    task automatic clear_logs();
        rxq[0].delete();
        rxq[1].delete();
        p8q.delete();
        p32q.delete();
        rise_q.delete();
        fall_q.delete();
    endtask

    initial begin
        int          t0;
        int          n8;
        logic [7:0]  e [$];
        int          exp8 [4] = '{40, 80, 120, 160};

        // Reset, then idle with no strobe.
        repeat (3) tick();
        rst = 1'b0;
        check("reset tx", tx[0], 1'b1);
        check("reset busy", busy[0], 1'b0);
        repeat (50) tick();
        check("idle 8b pulses", p8q.size(), 0);
        check("idle 32b pulses", p32q.size(), 0);
        check("idle busy rises", rise_q.size(), 0);

        // Single word at BAUD_DIV=4.
        clear_logs();
        send(32'h1234_5678, t0);
        wait_until(t0 + 200);
        e = '{8'h78, 8'h56, 8'h34, 8'h12};
        check_bytes(0, "single", e);
        check("single 8b count", p8q.size(), 4);
        if (p8q.size() == 4) begin
            for (int j = 0; j < 4; j++)
                check($sformatf("single 8b pulse %0d cycle", j), p8q[j] - t0, exp8[j]);
        end
        check("single 32b count", p32q.size(), 1);
        if (p32q.size() == 1) check("single 32b cycle", p32q[0] - t0, 160);
        check("single busy fall count", fall_q.size(), 1);
        if (fall_q.size() == 1) check("single busy fall cycle", fall_q[0] - t0, 161);

        // Start while busy is ignored.
        clear_logs();
        send(32'h1234_5678, t0);
        wait_until(t0 + 19);
        data  = 32'hFFFF_FFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_until(t0 + 200);
        check_bytes(0, "busy-ignore", e);
        check("busy-ignore 32b count", p32q.size(), 1);

        // Back-to-back with start held high.
        clear_logs();
        data  = 32'hA5A5_A5A5;
        start = 1'b1;
        tick();
        t0   = cyc;
        data = 32'h0000_0000;
        wait_until(t0 + 161);
        start = 1'b0;
        wait_until(t0 + 340);
        check("b2b busy rise count", rise_q.size(), 2);
        if (rise_q.size() == 2) check("b2b second accept cycle", rise_q[1] - t0 - 1, 161);
        check("b2b last stop high", txhist[t0 + 160], 1'b1);
        check("b2b idle gap high", txhist[t0 + 161], 1'b1);
        check("b2b next start low", txhist[t0 + 162], 1'b0);
        check("b2b 32b count", p32q.size(), 2);
        e = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
        check_bytes(0, "b2b", e);

        // Reset in the middle of byte 1.
        clear_logs();
        send(32'h1234_5678, t0);
        wait_until(t0 + 70);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset tx", tx[0], 1'b1);
        check("midreset busy", busy[0], 1'b0);
        n8 = p8q.size();
        check("midreset 8b before", n8, 1);
        repeat (100) tick();
        check("midreset no further 8b", p8q.size(), n8);
        check("midreset no 32b", p32q.size(), 0);
        clear_logs();
        send(32'hCAFE_F00D, t0);
        wait_until(t0 + 200);
        e = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
        check_bytes(0, "after-reset", e);
        check("after-reset 32b count", p32q.size(), 1);

        // Edge data at BAUD_DIV=2.
        clear_logs();
        send(32'h0000_0000, t0);
        wait_until(t0 + 170);
        send(32'hFFFF_FFFF, t0);
        wait_until(t0 + 170);
        e = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        check_bytes(1, "bd2 edge", e);
        check_bytes(0, "bd4 edge", e);
        check("bd2 framing errors", ferr[1], 0);
        check("bd4 framing errors", ferr[0], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
